// File: rtl/frame_sequencer_pkg.sv
// Shared types and default widths for the adaptive-thresholding frame controller.
// Imported by the sequencer top and its stage watchdog.
package frame_sequencer_pkg;

   localparam int WIDTH_BITS_DEF   = 8;
   localparam int HEIGHT_BITS_DEF  = 8;
   localparam int TIMEOUT_BITS_DEF = 20;
   localparam int OFFSET_W         = 8;
   localparam int CYCLES_W         = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILTER,
      S_DRAIN,
      S_THRESH,
      S_DONE,
      S_ERROR
   } seq_state_e;

   // Stages in which an engine is expected to make progress under supervision.
   function automatic logic stage_supervised(input seq_state_e s);
      return (s == S_FILTER) || (s == S_THRESH);
   endfunction

endpackage

// File: rtl/frame_sequencer_watchdog.sv
// Per-stage watchdog: counts while enabled, restarts on clear, and flags expiry
// in the cycle whose count would reach all-ones (2**TIMEOUT_BITS-1 enabled cycles).
module stage_watchdog #(
   parameter int TIMEOUT_BITS = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic count_en_i,
   output logic expired_o
);

   localparam logic [TIMEOUT_BITS-1:0] ONE  = TIMEOUT_BITS'(1);
   localparam logic [TIMEOUT_BITS-1:0] LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

   logic [TIMEOUT_BITS-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (count_en_i)
         count_d = count_q + ONE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // Independent of clear_i: the top derives clear from the next state, which
   // itself depends on expiry.
   assign expired_o = count_en_i && (count_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Frame controller: sequences box filter -> drain -> threshold, owns the image
// read port mux, supervises each stage with a watchdog and counts busy cycles.
module frame_sequencer
   import frame_sequencer_pkg::*;
#(
   parameter int WIDTH_BITS   = WIDTH_BITS_DEF,
   parameter int HEIGHT_BITS  = HEIGHT_BITS_DEF,
   parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   iStart,
   input  logic [OFFSET_W-1:0]    iOffset,
   output logic                   oBusy,
   output logic                   oDone,
   output logic                   oError,
   output logic                   oFilterEnable,
   input  logic                   iFilterFinished,
   input  logic [WIDTH_BITS-1:0]  iFilterCol,
   input  logic [HEIGHT_BITS-1:0] iFilterRow,
   output logic                   oThreshEnable,
   input  logic                   iThreshFinished,
   input  logic [WIDTH_BITS-1:0]  iThreshCol,
   input  logic [HEIGHT_BITS-1:0] iThreshRow,
   output logic [WIDTH_BITS-1:0]  oImageCol,
   output logic [HEIGHT_BITS-1:0] oImageRow,
   output logic [OFFSET_W-1:0]    oOffset,
   output logic [CYCLES_W-1:0]    oCycles
);

   localparam logic [CYCLES_W-1:0] CYC_ONE = CYCLES_W'(1);

   seq_state_e state_q, state_d;
   logic busy_q, done_q, error_q, fen_q, ten_q;
   logic [OFFSET_W-1:0] offset_q;
   logic [CYCLES_W-1:0] cycles_q, cycles_d;
   logic start_accept, wd_clear, wd_en, wd_expired;

   assign start_accept = (state_q == S_IDLE) && iStart;
   assign wd_clear     = (state_d != state_q);
   assign wd_en        = stage_supervised(state_q);

   stage_watchdog #(
      .TIMEOUT_BITS(TIMEOUT_BITS)
   ) u_watchdog (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (wd_clear),
      .count_en_i(wd_en),
      .expired_o (wd_expired)
   );

   // Watchdog expiry wins over a finished flag arriving in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (iStart) state_d = S_FILTER;
         S_FILTER: begin
            if (wd_expired)           state_d = S_ERROR;
            else if (iFilterFinished) state_d = S_DRAIN;
         end
         // One extra enabled cycle lets the filter's registered last write land.
         S_DRAIN:  state_d = S_THRESH;
         S_THRESH: begin
            if (wd_expired)           state_d = S_ERROR;
            else if (iThreshFinished) state_d = S_DONE;
         end
         S_DONE:   state_d = S_IDLE;
         S_ERROR:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // The accept cycle counts as the first busy cycle; the counter then
   // saturates rather than wrapping.
   always_comb begin
      cycles_d = cycles_q;
      if (start_accept)
         cycles_d = CYC_ONE;
      else if (busy_q && (cycles_q != '1))
         cycles_d = cycles_q + CYC_ONE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         fen_q    <= 1'b0;
         ten_q    <= 1'b0;
         offset_q <= '0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
         fen_q    <= (state_d == S_FILTER) || (state_d == S_DRAIN);
         ten_q    <= (state_d == S_THRESH);
         cycles_q <= cycles_d;
         if (start_accept) begin
            offset_q <= iOffset;
            error_q  <= 1'b0;
         end else if (state_d == S_ERROR) begin
            error_q  <= 1'b1;
         end
      end
   end

   always_comb begin
      oImageCol = '0;
      oImageRow = '0;
      unique case (state_q)
         S_FILTER, S_DRAIN: begin
            oImageCol = iFilterCol;
            oImageRow = iFilterRow;
         end
         S_THRESH: begin
            oImageCol = iThreshCol;
            oImageRow = iThreshRow;
         end
         default: ;
      endcase
   end

   assign oBusy         = busy_q;
   assign oDone         = done_q;
   assign oError        = error_q;
   assign oFilterEnable = fen_q;
   assign oThreshEnable = ten_q;
   assign oOffset       = offset_q;
   assign oCycles       = cycles_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a vector table for the normal frame plus
// hand sequences for watchdog expiry, mid-frame reset and a minimal frame.
module tb_frame_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        iStart;
   logic [7:0]  iOffset;
   logic        oBusy, oDone, oError, oFilterEnable, oThreshEnable;
   logic        iFilterFinished, iThreshFinished;
   logic [7:0]  iFilterCol, iFilterRow, iThreshCol, iThreshRow;
   logic [7:0]  oImageCol, oImageRow, oOffset;
   logic [31:0] oCycles;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   always #5 clock = ~clock;

   frame_sequencer #(
      .WIDTH_BITS(8), .HEIGHT_BITS(8), .TIMEOUT_BITS(4)
   ) dut (
      .clock(clock), .reset(reset), .iStart(iStart), .iOffset(iOffset),
      .oBusy(oBusy), .oDone(oDone), .oError(oError),
      .oFilterEnable(oFilterEnable), .iFilterFinished(iFilterFinished),
      .iFilterCol(iFilterCol), .iFilterRow(iFilterRow),
      .oThreshEnable(oThreshEnable), .iThreshFinished(iThreshFinished),
      .iThreshCol(iThreshCol), .iThreshRow(iThreshRow),
      .oImageCol(oImageCol), .oImageRow(oImageRow),
      .oOffset(oOffset), .oCycles(oCycles)
   );

   always @(negedge clock) if (oDone) done_cnt++;

   typedef struct {
      logic        start;
      logic [7:0]  off;
      logic        ffin;
      logic        tfin;
      logic        busy;
      logic        done;
      logic        err;
      logic        fen;
      logic        ten;
      logic [7:0]  col;
      logic [7:0]  row;
      logic [7:0]  offo;
      logic [31:0] cyc;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, ".busy"},   32'(oBusy), 32'd0);
      chk({tag, ".done"},   32'(oDone), 32'd0);
      chk({tag, ".err"},    32'(oError), 32'd0);
      chk({tag, ".fen"},    32'(oFilterEnable), 32'd0);
      chk({tag, ".ten"},    32'(oThreshEnable), 32'd0);
      chk({tag, ".col"},    32'(oImageCol), 32'd0);
      chk({tag, ".row"},    32'(oImageRow), 32'd0);
      chk({tag, ".offset"}, 32'(oOffset), 32'd0);
      chk({tag, ".cycles"}, oCycles, 32'd0);
   endtask

   initial begin
      int n;
      //          start off    ffin  tfin  busy  done  err   fen   ten   col     row     offo   cycles
      vecs[0]  = '{1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'd7, 32'd1};
      vecs[1]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'd7, 32'd2};
      vecs[2]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'd7, 32'd3};
      vecs[3]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'd7, 32'd4};
      vecs[4]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'd7, 32'd5};
      vecs[5]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'd7, 32'd6};
      vecs[6]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h56, 8'h78, 8'd7, 32'd7};
      vecs[7]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h56, 8'h78, 8'd7, 32'd8};
      vecs[8]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h56, 8'h78, 8'd7, 32'd9};
      vecs[9]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd7, 32'd10};
      vecs[10] = '{1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd7, 32'd11};
      vecs[11] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd7, 32'd11};

      reset = 1'b1; iStart = 1'b0; iOffset = 8'd0;
      iFilterFinished = 1'b0; iThreshFinished = 1'b0;
      iFilterCol = 8'h12; iFilterRow = 8'h34; iThreshCol = 8'h56; iThreshRow = 8'h78;
      #2;
      chk_idle_zero("reset");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Normal frame, offset 7: 5 filter cycles, drain, 3 thresh cycles, done.
      for (int i = 0; i < 12; i++) begin
         iStart = vecs[i].start; iOffset = vecs[i].off;
         iFilterFinished = vecs[i].ffin; iThreshFinished = vecs[i].tfin;
         tick();
         chk($sformatf("v%0d.busy", i),   32'(oBusy), 32'(vecs[i].busy));
         chk($sformatf("v%0d.done", i),   32'(oDone), 32'(vecs[i].done));
         chk($sformatf("v%0d.err", i),    32'(oError), 32'(vecs[i].err));
         chk($sformatf("v%0d.fen", i),    32'(oFilterEnable), 32'(vecs[i].fen));
         chk($sformatf("v%0d.ten", i),    32'(oThreshEnable), 32'(vecs[i].ten));
         chk($sformatf("v%0d.col", i),    32'(oImageCol), 32'(vecs[i].col));
         chk($sformatf("v%0d.row", i),    32'(oImageRow), 32'(vecs[i].row));
         chk($sformatf("v%0d.offset", i), 32'(oOffset), 32'(vecs[i].offo));
         chk($sformatf("v%0d.cycles", i), oCycles, vecs[i].cyc);
      end
      iStart = 1'b0;
      chk("normal.done_pulses", 32'(done_cnt), 32'd1);

      // Watchdog: finished arrives on the expiry cycle (15th FILTER cycle) -> ERROR.
      iStart = 1'b1; iOffset = 8'd3;
      tick();
      iStart = 1'b0;
      n = 0;
      for (int k = 0; k < 14; k++) begin
         if (oFilterEnable && !oError) n++;
         tick();
      end
      chk("wd.filter_cycles", 32'(n), 32'd14);
      chk("wd.still_filter", 32'(oFilterEnable), 32'd1);
      iFilterFinished = 1'b1;
      tick();
      iFilterFinished = 1'b0;
      chk("wd.err", 32'(oError), 32'd1);
      chk("wd.busy", 32'(oBusy), 32'd1);
      chk("wd.fen", 32'(oFilterEnable), 32'd0);
      chk("wd.ten", 32'(oThreshEnable), 32'd0);
      chk("wd.done", 32'(oDone), 32'd0);
      tick();
      chk("wd.idle_busy", 32'(oBusy), 32'd0);
      chk("wd.sticky_err", 32'(oError), 32'd1);
      chk("wd.cycles", oCycles, 32'd17);

      // Next start clears the error; then reset lands while in THRESH.
      iStart = 1'b1; iOffset = 8'd5;
      tick();
      iStart = 1'b0;
      chk("restart.err_clear", 32'(oError), 32'd0);
      chk("restart.offset", 32'(oOffset), 32'd5);
      iFilterFinished = 1'b1;
      tick();
      iFilterFinished = 1'b0;
      tick();
      chk("rst_thresh.ten", 32'(oThreshEnable), 32'd1);
      #3 reset = 1'b1;
      #1;
      chk_idle_zero("midreset");
      #1 reset = 1'b0;
      tick();
      chk("postreset.busy", 32'(oBusy), 32'd0);

      // Minimal frame: one cycle per engine -> 3 cycles overhead, total 5.
      iStart = 1'b1; iOffset = 8'd8;
      tick();
      iStart = 1'b0; iFilterFinished = 1'b1;
      tick();
      iFilterFinished = 1'b0;
      tick();
      chk("min.thresh", 32'(oThreshEnable), 32'd1);
      iThreshFinished = 1'b1;
      tick();
      iThreshFinished = 1'b0;
      chk("min.done", 32'(oDone), 32'd1);
      chk("min.offset", 32'(oOffset), 32'd8);
      tick();
      chk("min.busy_fall", 32'(oBusy), 32'd0);
      chk("min.cycles", oCycles, 32'd5);
      chk("total.done_pulses", 32'(done_cnt), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
